// File: rtl/echo_path_model.sv
// echo_path_model
//
// Synthetic echo path for an echo-cancellation test setup. Each accepted
// sample is mixed with an attenuated copy of the sample accepted LAG strobes
// earlier. The attenuated echo term is also exposed on its own, so the
// canceller under test has a known answer to compare against.
//
// Parameters:
//   LAG         echo delay in samples (1..16)
//   ECHO_SHIFT  echo attenuation as an arithmetic right shift (0..15)
//
// Ports:
//   clk_operation  in   operation clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   signal         in   16-bit signed input sample
//   signal_valid   in   one-cycle strobe; signal is consumed on this edge
//   mixed_out      out  16-bit signed signal + echo_out, registered
//   echo_out       out  16-bit signed delayed >>> ECHO_SHIFT, registered
//   out_valid      out  one-cycle strobe qualifying mixed_out / echo_out
//   primed         out  high once LAG samples have been accepted since reset
//
// Build option:
//   ECHO_SATURATE_EN  defined   -> mixed_out saturates to +32767 / -32768
//                     undefined -> mixed_out wraps (low 16 bits of the sum)

module echo_path_model #(
  parameter int LAG        = 4,
  parameter int ECHO_SHIFT = 1
) (
  input  logic               clk_operation,
  input  logic               rst_n,
  input  logic signed [15:0] signal,
  input  logic               signal_valid,
  output logic signed [15:0] mixed_out,
  output logic signed [15:0] echo_out,
  output logic               out_valid,
  output logic               primed
);

  localparam int PTR_W  = (LAG > 1) ? $clog2(LAG) : 1;
  localparam int FILL_W = $clog2(LAG + 1);

  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(LAG - 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(LAG);

  logic signed [15:0] delay_buf [LAG];
  logic [PTR_W-1:0]   wr_ptr;
  logic [FILL_W-1:0]  fill;

  logic signed [15:0] delayed;
  logic signed [15:0] echo_next;
  logic signed [16:0] sum;
  logic signed [15:0] mixed_next;
  logic [PTR_W-1:0]   wr_ptr_next;
  logic [FILL_W-1:0]  fill_next;

  // Datapath for the sample currently on the input. The slot about to be
  // overwritten holds the sample from exactly LAG strobes ago.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    delayed     = delay_buf[wr_ptr];
    echo_next   = delayed >>> ECHO_SHIFT;
    sum         = {signal[15], signal} + {echo_next[15], echo_next};
    mixed_next  = sum[15:0];
    wr_ptr_next = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
    fill_next   = (fill == FILL_MAX) ? fill : fill + FILL_W'(1);

`ifdef ECHO_SATURATE_EN
    // The top two bits of the 17-bit sum disagree only when the result
    // leaves the signed 16-bit range; the sign bit tells which rail to hit.
    if (sum[16] != sum[15]) begin
      mixed_next = sum[16] ? 16'sh8000 : 16'sh7fff;
    end
`endif
  end

  always_ff @(posedge clk_operation or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the delay line is reset explicitly because the first LAG
      // outputs must see a zero echo; it cannot be left to power-up contents.
      for (int i = 0; i < LAG; i++) begin
        delay_buf[i] <= '0;
      end
      wr_ptr    <= '0;
      fill      <= '0;
      mixed_out <= '0;
      echo_out  <= '0;
      out_valid <= 1'b0;
      primed    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep the read of delay_buf[wr_ptr]
      // (in the comb block) ahead of this write within the same edge.
      out_valid <= signal_valid;
      if (signal_valid) begin
        delay_buf[wr_ptr] <= signal;
        wr_ptr            <= wr_ptr_next;
        fill              <= fill_next;
        mixed_out         <= mixed_next;
        echo_out          <= echo_next;
        // fill saturates, so once primed this stays high until reset.
        primed            <= (fill_next == FILL_MAX);
      end
    end
  end

endmodule

// File: tb/tb_echo_path_model.sv
// Scoreboard bench for echo_path_model: a LAG=4/ECHO_SHIFT=1 instance for the
// fill, saturation, rounding, spacing and reset scenarios, and a LAG=1/
// ECHO_SHIFT=0 instance for the pointer-wrap case.

module tb_echo_path_model;

  typedef struct {
    logic signed [15:0] mixed;
    logic signed [15:0] echo;
    logic               primed;
  } exp_t;

  logic               clk;
  logic               rst_n;
  logic signed [15:0] signal0, signal1;
  logic               valid0, valid1;
  logic signed [15:0] mixed0, mixed1, echo0, echo1;
  logic               out_valid0, out_valid1, primed0, primed1;

  exp_t q0[$];
  exp_t q1[$];
  exp_t last0, last1, e0, e1;
  int   pass_cnt, total_cnt;
  int   sent0, sent1, seen0, seen1;

  echo_path_model #(.LAG(4), .ECHO_SHIFT(1)) dut (
    .clk_operation(clk), .rst_n(rst_n), .signal(signal0), .signal_valid(valid0),
    .mixed_out(mixed0), .echo_out(echo0), .out_valid(out_valid0), .primed(primed0)
  );

  echo_path_model #(.LAG(1), .ECHO_SHIFT(0)) dut_lag1 (
    .clk_operation(clk), .rst_n(rst_n), .signal(signal1), .signal_valid(valid1),
    .mixed_out(mixed1), .echo_out(echo1), .out_valid(out_valid1), .primed(primed1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Issue one strobe at the current negedge, then leave `gap` idle cycles.
  // A gap of 0 lets the next call re-raise valid in the same timestep.
  task automatic send(input int which, input int v, input int m, input int ec,
                      input int p, input int gap);
    exp_t e;
    e.mixed  = 16'(m);
    e.echo   = 16'(ec);
    e.primed = p[0];
    if (which == 0) begin
      signal0 = 16'(v); valid0 = 1'b1; q0.push_back(e); sent0++;
    end else begin
      signal1 = 16'(v); valid1 = 1'b1; q1.push_back(e); sent1++;
    end
    @(negedge clk);
    valid0 = 1'b0;
    valid1 = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Monitors: pop on out_valid, otherwise outputs must hold the last response.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid0) begin
        seen0++;
        if (q0.size() == 0) begin
          check("lag4_unexpected_valid", 1, 0);
        end else begin
          e0 = q0.pop_front();
          check("lag4_mixed", mixed0, e0.mixed);
          check("lag4_echo", echo0, e0.echo);
          check("lag4_primed", primed0, e0.primed);
          last0 = e0;
        end
      end else begin
        check("lag4_hold_mixed", mixed0, last0.mixed);
        check("lag4_hold_echo", echo0, last0.echo);
        check("lag4_hold_primed", primed0, last0.primed);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid1) begin
        seen1++;
        if (q1.size() == 0) begin
          check("lag1_unexpected_valid", 1, 0);
        end else begin
          e1 = q1.pop_front();
          check("lag1_mixed", mixed1, e1.mixed);
          check("lag1_echo", echo1, e1.echo);
          check("lag1_primed", primed1, e1.primed);
          last1 = e1;
        end
      end else begin
        check("lag1_hold_mixed", mixed1, last1.mixed);
        check("lag1_hold_echo", echo1, last1.echo);
        check("lag1_hold_primed", primed1, last1.primed);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // Fill-and-echo vectors (LAG=4, ECHO_SHIFT=1).
  int fill_in    [6] = '{100, 200, 300, 400, 500, 600};
  int fill_mixed [6] = '{100, 200, 300, 400, 550, 700};
  int fill_echo  [6] = '{0, 0, 0, 0, 50, 100};
  int fill_prim  [6] = '{0, 0, 0, 1, 1, 1};

  // Saturation / negative-rounding vectors, starting from a fresh reset.
  int sat_in    [15] = '{32767, 0, 0, 0, 30000, -32768, 0, 0, 0, -30000,
                         -3, 0, 0, 0, 0};
  int sat_echo  [15] = '{0, 0, 0, 0, 16383, 0, 0, 0, 15000, -16384,
                         0, 0, 0, -15000, -2};
`ifdef ECHO_SATURATE_EN
  int sat_mixed [15] = '{32767, 0, 0, 0, 32767, -32768, 0, 0, 15000, -32768,
                         -3, 0, 0, -15000, -2};
`else
  int sat_mixed [15] = '{32767, 0, 0, 0, -19153, -32768, 0, 0, 15000, 19152,
                         -3, 0, 0, -15000, -2};
`endif

  // Wrap vectors (LAG=1, ECHO_SHIFT=0).
  int wrap_in    [3] = '{10, 20, 30};
  int wrap_mixed [3] = '{10, 30, 50};
  int wrap_echo  [3] = '{0, 10, 20};

  task automatic clear_last();
    last0 = '{mixed: 16'sd0, echo: 16'sd0, primed: 1'b0};
    last1 = '{mixed: 16'sd0, echo: 16'sd0, primed: 1'b0};
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0;
    sent0 = 0; sent1 = 0; seen0 = 0; seen1 = 0;
    clear_last();
    rst_n = 1'b0;
    valid0 = 1'b0; valid1 = 1'b0;
    signal0 = '0; signal1 = '0;
    repeat (2) @(negedge clk);

    check("reset_mixed", mixed0, 0);
    check("reset_echo", echo0, 0);
    check("reset_out_valid", out_valid0, 0);
    check("reset_primed", primed0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fill and echo, strobes every cycle.
    for (int i = 0; i < 6; i++)
      send(0, fill_in[i], fill_mixed[i], fill_echo[i], fill_prim[i], 0);
    repeat (2) @(negedge clk);

    // Mid-stream reset between edges: outputs must clear without a clock.
    @(posedge clk);
    #2 rst_n = 1'b0;
    clear_last();
    #1;
    check("async_reset_mixed", mixed0, 0);
    check("async_reset_echo", echo0, 0);
    check("async_reset_primed", primed0, 0);
    check("async_reset_out_valid", out_valid0, 0);
    // A strobe seen while reset is still low must be ignored.
    @(negedge clk);
    signal0 = 16'sd999; valid0 = 1'b1;
    @(negedge clk);
    valid0 = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Same samples again with idle gaps of 0..5: identical responses.
    for (int i = 0; i < 6; i++)
      send(0, fill_in[i], fill_mixed[i], fill_echo[i], fill_prim[i], i);
    repeat (2) @(negedge clk);

    // Fresh start for saturation and rounding, gaps cycling 7..0.
    rst_n = 1'b0;
    clear_last();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 15; i++)
      send(0, sat_in[i], sat_mixed[i], sat_echo[i], (i >= 3) ? 1 : 0, 7 - (i % 8));
    repeat (2) @(negedge clk);

    // LAG=1 pointer wrap: primed from the very first output.
    for (int i = 0; i < 3; i++)
      send(1, wrap_in[i], wrap_mixed[i], wrap_echo[i], 1, 0);
    repeat (3) @(negedge clk);

    check("lag4_queue_drained", q0.size(), 0);
    check("lag1_queue_drained", q1.size(), 0);
    check("lag4_valid_pulses", seen0, sent0);
    check("lag1_valid_pulses", seen1, sent1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
